// File: rtl/bucket_write_packer.sv
// bucket_write_packer
//   Collects address-contiguous 32-bit bucket words into a local buffer. When a
//   burst closes, it pushes one header word and then the buffered data words
//   into BucketWriteFIFO, so the PSRAM sees long bursts.
//   Each word covers two halfwords, so contiguous words step the address by 2.
// Ports
//   clk75, rst_n                  clock, async active-low reset
//   in_valid/in_ready/in_data/in_addr  upstream word stream (valid/ready)
//   in_flush                      one-cycle pulse, closes the open burst
//   BucketWriteFIFO_WriteData/_push/_full  FIFO write side
//   busy                          high whenever state is not IDLE
module bucket_write_packer #(
  parameter int MAX_WORDS = 16,   // 1..63
  parameter int TIMEOUT   = 64    // 1..1023
) (
  input  logic        clk75,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [22:0] in_addr,
  input  logic        in_flush,
  output logic [31:0] BucketWriteFIFO_WriteData,
  output logic        BucketWriteFIFO_push,
  input  logic        BucketWriteFIFO_full,
  output logic        busy
);

  localparam int         AW      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int         DEPTH   = 1 << AW;
  localparam logic [5:0] MAX_W   = 6'(MAX_WORDS);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HDR, DATA} state_t;

  typedef struct packed {
    logic        rsv1;
    logic [6:0]  hwCount;   // halfword count = 2 * words
    logic        rsv0;
    logic [22:0] base;
  } hdr_t;

  state_t      state;
  logic [5:0]  count;
  logic [5:0]  rdPtr;
  logic [22:0] base;
  logic [22:0] expAddr;
  logic [9:0]  idleCnt;
  logic [31:0] wordBuf [DEPTH];
  logic        accept;
  logic        closeReq;
  logic        push;
  hdr_t        hdr;

  // Next contiguous address; wraps naturally at 2^23.
  assign expAddr = base + {16'd0, count, 1'b0};

  assign closeReq = in_flush || (in_valid && (in_addr != expAddr)) ||
                    (count == MAX_W) || (idleCnt == TO_LAST);

  // Gated by rst_n so the upstream sees no ready while reset is held.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      COLLECT: in_ready = in_valid && (in_addr == expAddr) && (count < MAX_W) && !in_flush;
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready && rst_n;
  end

  assign accept = in_valid && in_ready;
  assign push   = ((state == HDR) || (state == DATA)) && !BucketWriteFIFO_full;
  assign busy   = (state != IDLE);

  assign hdr = '{rsv1: 1'b0, hwCount: {count, 1'b0}, rsv0: 1'b0, base: base};

  always_comb begin
    BucketWriteFIFO_WriteData = '0;
    case (state)
      HDR:     BucketWriteFIFO_WriteData = hdr;
      DATA:    BucketWriteFIFO_WriteData = wordBuf[rdPtr[AW-1:0]];
      default: BucketWriteFIFO_WriteData = '0;
    endcase
  end
  assign BucketWriteFIFO_push = push;

  // Data buffer needs no reset: only entries below count are ever read.
  always_ff @(posedge clk75) begin
    if (accept) wordBuf[(state == IDLE) ? '0 : count[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk75 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      rdPtr   <= '0;
      base    <= '0;
      idleCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            base    <= in_addr;
            count   <= 6'd1;
            idleCnt <= '0;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          // A word accepted on the timeout cycle still joins this burst.
          if (accept) begin
            count   <= count + 6'd1;
            idleCnt <= '0;
          end else begin
            idleCnt <= idleCnt + 10'd1;
          end
          if (closeReq) state <= HDR;
        end
        HDR: begin
          if (push) begin
            rdPtr <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (push) begin
            rdPtr <= rdPtr + 6'd1;
            if (rdPtr == count - 6'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bucket_write_packer.sv
// Directed bench for bucket_write_packer (MAX_WORDS=16, TIMEOUT=64).
// Pushes are captured at the posedge where they take effect and compared to
// hand-computed burst images.
module tb_bucket_write_packer;

  logic        clk75 = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [22:0] in_addr = '0;
  logic        in_flush = 1'b0;
  logic [31:0] wd;
  logic        push;
  logic        full = 1'b0;
  logic        busy;

  int nCmp = 0;
  int nBad = 0;

  logic [31:0] gotQ[$];
  logic [31:0] expQ[$];
  logic        pPush = 1'b0;
  logic [31:0] pData = '0;

  bucket_write_packer #(.MAX_WORDS(16), .TIMEOUT(64)) dut (
    .clk75(clk75), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .in_flush(in_flush),
    .BucketWriteFIFO_WriteData(wd), .BucketWriteFIFO_push(push),
    .BucketWriteFIFO_full(full), .busy(busy)
  );

  always #5 clk75 = ~clk75;

  // Sample mid-cycle, commit at the edge only if reset did not intervene.
  always @(negedge clk75) begin
    pPush <= push;
    pData <= wd;
  end
  always @(posedge clk75) begin
    if (pPush && rst_n) gotQ.push_back(pData);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nCmp++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic put(input logic [31:0] d, input logic [22:0] a, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    in_valid = 1'b1; in_data = d; in_addr = a;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk75);
      if (in_ready) acc = 1'b1; else stalls++;
      @(posedge clk75); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("put_accept", 32'(acc), 32'd1);
  endtask

  task automatic flush();
    in_flush = 1'b1;
    @(posedge clk75); #1;
    in_flush = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk75);
      if (!busy) break;
    end
    chk($sformatf("%s_idle", tag), 32'(busy), 32'd0);
  endtask

  task automatic checkBurst(input string tag, input int from);
    chk($sformatf("%s_npush", tag), 32'(gotQ.size() - from), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      if (from + i < gotQ.size()) chk($sformatf("%s_w%0d", tag, i), gotQ[from + i], expQ[i]);
    expQ.delete();
  endtask

  initial begin
    int st, q0, cyc, bad, unst;

    // reset state
    #12;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_wdata", wd, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk75); rst_n = 1'b1;
    #1 chk("idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk75); #1;

    // flush in IDLE is ignored
    flush();
    @(negedge clk75);
    chk("idle_flush_busy", 32'(busy), 32'd0);
    @(posedge clk75); #1;

    // contiguous run + flush
    q0 = gotQ.size();
    for (int i = 0; i < 4; i++) put(32'hA000_0000 + i, 23'h100 + 23'(2 * i), st);
    flush();
    waitIdle("contig");
    expQ = '{32'h0800_0100, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    checkBurst("contig", q0);

    // max length: 16-word burst, then 4 words closed by timeout
    @(posedge clk75); #1;
    q0 = gotQ.size();
    for (int i = 0; i < 20; i++) begin
      put(32'hB000_0000 + i, 23'h1000 + 23'(2 * i), st);
      if (i == 16) chk("max_stall", 32'(st), 32'd18);
    end
    waitIdle("max");
    expQ.push_back(32'h2000_1000);
    for (int i = 0; i < 16; i++) expQ.push_back(32'hB000_0000 + i);
    expQ.push_back(32'h0800_1020);
    for (int i = 16; i < 20; i++) expQ.push_back(32'hB000_0000 + i);
    checkBurst("max", q0);

    // discontinuity holds the new word until IDLE
    @(posedge clk75); #1;
    q0 = gotQ.size();
    put(32'hC000_0000, 23'h10, st);
    put(32'hC000_0001, 23'h12, st);
    put(32'hC000_0002, 23'h40, st);
    chk("disc_stall", 32'(st), 32'd4);
    flush();
    waitIdle("disc");
    expQ = '{32'h0400_0010, 32'hC000_0000, 32'hC000_0001, 32'h0200_0040, 32'hC000_0002};
    checkBurst("disc", q0);

    // address wrap is contiguous
    @(posedge clk75); #1;
    q0 = gotQ.size();
    put(32'hF000_0000, 23'h7F_FFFE, st);
    put(32'hF000_0001, 23'h00_0000, st);
    chk("wrap_stall", 32'(st), 32'd0);
    flush();
    waitIdle("wrap");
    expQ = '{32'h047F_FFFE, 32'hF000_0000, 32'hF000_0001};
    checkBurst("wrap", q0);

    // backpressure during DATA
    @(posedge clk75); #1;
    q0 = gotQ.size();
    for (int i = 0; i < 3; i++) put(32'hD000_0000 + i, 23'h300 + 23'(2 * i), st);
    flush();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk75);
      if (gotQ.size() >= q0 + 1) break;
    end
    @(posedge clk75); #1;     // D0 pushed on this edge, now holding D1
    full = 1'b1;
    bad = 0; unst = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk75);
      if (push) bad++;
      if (wd !== 32'hD000_0001) unst++;
    end
    chk("bp_push", 32'(bad), 32'd0);
    chk("bp_stable", 32'(unst), 32'd0);
    chk("bp_count", 32'(gotQ.size() - q0), 32'd2);
    @(posedge clk75); #1;
    full = 1'b0;
    waitIdle("bp");
    expQ = '{32'h0600_0300, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002};
    checkBurst("bp", q0);

    // timeout on a single word
    @(posedge clk75); #1;
    q0 = gotQ.size();
    put(32'hE000_0000, 23'h2000, st);
    cyc = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk75);
      if (push) break;
      cyc++;
    end
    chk("to_latency", 32'(cyc), 32'd64);
    chk("to_hdr", wd, 32'h0200_2000);
    waitIdle("to");
    expQ = '{32'h0200_2000, 32'hE000_0000};
    checkBurst("to", q0);

    // reset during DATA
    @(posedge clk75); #1;
    q0 = gotQ.size();
    for (int i = 0; i < 4; i++) put(32'h5000_0000 + i, 23'h500 + 23'(2 * i), st);
    flush();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk75);
      if (gotQ.size() >= q0 + 2) break;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_push", 32'(push), 32'd0);
    chk("mid_rst_wdata", wd, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk75);
    @(negedge clk75); rst_n = 1'b1;
    repeat (20) @(negedge clk75);
    chk("mid_rst_nopush", 32'(gotQ.size() - q0), 32'd2);
    @(posedge clk75); #1;
    put(32'h6000_0000, 23'h600, st);
    flush();
    waitIdle("post_rst");
    expQ = '{32'h0200_0600, 32'h6000_0000};
    checkBurst("post_rst", q0 + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
